// File: rtl/manchester_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : manchester_link_pkg
// Brief    : Shared types and constants for the Manchester serial link.
// Revision : 1.0 - initial release
// ============================================================================
package manchester_link_pkg;

  localparam int FRAME_SIZE  = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEST_W      = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  function automatic int dest_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/manchester_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Round-robin winner select: rotate, priority-encode, rotate back.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int DEST_W  = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [DEST_W-1:0]  rr_last,
  output logic [DEST_W-1:0]  winner,
  output logic               any_req
);

  localparam int c_SUM_W = DEST_W + 1;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic [c_SUM_W-1:0]   w_base;
  logic [c_SUM_W-1:0]   w_off;
  logic [c_SUM_W-1:0]   w_sum;
  logic [c_SUM_W-1:0]   w_wrap;

  // Bit 0 of the rotated vector is the requester just after rr_last.
  assign w_base  = c_SUM_W'(rr_last) + c_SUM_W'(1);
  assign w_dbl   = {req, req};
  assign w_shift = w_dbl >> w_base;
  assign w_rot   = w_shift[NUM_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = c_SUM_W'(i);
    end
  end

  assign w_sum   = w_base + w_off;
  assign w_wrap  = (w_sum >= c_SUM_W'(NUM_REQ)) ? (w_sum - c_SUM_W'(NUM_REQ)) : w_sum;
  assign winner  = DEST_W'(w_wrap);
  assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/manchester_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : manchester_tx_arbiter
// Brief    : Round-robin burst arbiter feeding the Manchester encoder, with a
//            forced quiet gap after each grant. ARB_STATS_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module manchester_tx_arbiter
  import manchester_link_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = FRAME_SIZE,
  parameter int MAX_BURST    = 16,
  parameter int GAP_CYCLES   = 4,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ*DATA_W-1:0]  s_axis_tdata,
  input  logic [NUM_REQ-1:0]         s_axis_tvalid,
  input  logic [NUM_REQ-1:0]         s_axis_tlast,
  output logic [NUM_REQ-1:0]         s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [$clog2(NUM_REQ)-1:0] m_axis_tdest,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic                       timeout_pulse
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_count,
  output logic [15:0]                timeout_count
`endif
);

  localparam int         c_DEST_W       = dest_width(NUM_REQ);
  localparam logic [7:0] c_BURST_LAST   = 8'(MAX_BURST - 1);
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);
  localparam logic [7:0] c_GAP_LAST     = 8'(GAP_CYCLES - 1);
  localparam arb_state_t c_REL_STATE    = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [c_DEST_W-1:0] r_grant;
  logic [c_DEST_W-1:0] r_rr_last;
  logic [c_DEST_W-1:0] w_winner;
  logic                w_any_req;
  logic [7:0]          r_beat_cnt;
  logic [7:0]          r_idle_cnt;
  logic [7:0]          r_gap_cnt;
  logic                r_timeout_pulse;
  logic                w_in_grant;
  logic                w_g_valid;
  logic                w_g_last;
  logic                w_hs;
  logic                w_release_last;
  logic                w_timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .DEST_W  (c_DEST_W)
  ) u_rr_pick (
    .req     (s_axis_tvalid),
    .rr_last (r_rr_last),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  assign w_in_grant     = (r_state == GRANT);
  assign w_g_valid      = s_axis_tvalid[r_grant];
  assign w_g_last       = s_axis_tlast[r_grant] | (r_beat_cnt == c_BURST_LAST);
  assign w_hs           = w_in_grant & w_g_valid & m_axis_tready;
  assign w_release_last = w_hs & w_g_last;
  assign w_timeout      = w_in_grant & ~w_g_valid & (r_idle_cnt == c_TIMEOUT_LAST);

  // Zero-latency pass-through of the granted requester.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdest  = '0;
    s_axis_tready = '0;
    if (w_in_grant) begin
      m_axis_tdata           = s_axis_tdata[r_grant*DATA_W +: DATA_W];
      m_axis_tvalid          = w_g_valid;
      m_axis_tlast           = w_g_last;
      m_axis_tdest           = r_grant;
      s_axis_tready[r_grant] = m_axis_tready;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = GRANT;
      GRANT:   if (w_release_last || w_timeout) w_state_nxt = c_REL_STATE;
      GAP:     if (r_gap_cnt == c_GAP_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant         <= '0;
      r_rr_last       <= c_DEST_W'(NUM_REQ - 1);
      r_beat_cnt      <= '0;
      r_idle_cnt      <= '0;
      r_gap_cnt       <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
      case (r_state)
        IDLE: begin
          r_gap_cnt <= '0;
          if (w_any_req) begin
            r_grant    <= w_winner;
            r_rr_last  <= w_winner;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release_last || w_timeout) begin
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_gap_cnt  <= '0;
          end else begin
            if (w_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
            r_idle_cnt <= w_g_valid ? 8'd0 : (r_idle_cnt + 8'd1);
          end
        end
        GAP:     r_gap_cnt <= r_gap_cnt + 8'd1;
        default: r_gap_cnt <= '0;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign timeout_pulse = r_timeout_pulse;

`ifdef ARB_STATS_EN
  logic [15:0] r_timeout_count;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_cnt <= '0;
      end else if ((r_state == IDLE) && w_any_req && (w_winner == c_DEST_W'(g))
                   && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign grant_count[g*16 +: 16] = r_cnt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timeout_count <= '0;
    end else if (w_timeout && (r_timeout_count != 16'hFFFF)) begin
      r_timeout_count <= r_timeout_count + 16'd1;
    end
  end

  assign timeout_count = r_timeout_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_manchester_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_manchester_tx_arbiter
// Brief    : Scoreboard bench for manchester_tx_arbiter (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_manchester_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int GAP = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] dest;
    logic       last;
  } beat_t;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NR*DW-1:0] s_axis_tdata;
  logic [NR-1:0]    s_axis_tvalid;
  logic [NR-1:0]    s_axis_tlast;
  logic [NR-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [1:0]       m_axis_tdest;
  logic             m_axis_tready;
  logic             busy;
  logic             timeout_pulse;
`ifdef ARB_STATS_EN
  logic [NR*16-1:0] grant_count;
  logic [15:0]      timeout_count;
`endif

  always #5 aclk = ~aclk;

  manchester_tx_arbiter dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
`ifdef ARB_STATS_EN
    ,
    .grant_count   (grant_count),
    .timeout_count (timeout_count)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          tp_count = 0;
  int          tp_cyc   = 0;
  int          ng_bad   = 0;
  beat_t       exp_q[$];
  int          hs_cyc[$];
  logic [8:0]  src_q[NR][$];
  logic [NR-1:0] hs_mask;
  beat_t       mon_e;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_beat;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int hs_at(input int i);
    if (i < hs_cyc.size()) return hs_cyc[i];
    return -1000;
  endfunction

  task automatic src_push(input int i, input logic [7:0] d, input logic last);
    src_q[i].push_back({last, d});
  endtask

  task automatic exp_push(input logic [7:0] d, input logic [1:0] dest, input logic last);
    exp_q.push_back('{d: d, dest: dest, last: last});
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk); #1;
      if (exp_q.size() == 0) break;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    hs_cyc.delete();
    tp_count      = 0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Requester model: pops on handshake, presents the queue head otherwise.
  initial begin
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    forever begin
      @(posedge aclk);
      hs_mask = s_axis_tvalid & s_axis_tready;
      #2;
      for (int i = 0; i < NR; i++) begin
        if (hs_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          s_axis_tvalid[i]          = 1'b1;
          s_axis_tdata[i*DW +: DW]  = src_q[i][0][7:0];
          s_axis_tlast[i]           = src_q[i][0][8];
        end else begin
          s_axis_tvalid[i]          = 1'b0;
          s_axis_tdata[i*DW +: DW]  = '0;
          s_axis_tlast[i]           = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on every m_axis handshake, plus stall/ready checks.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if ((s_axis_tready & ~(4'b0001 << m_axis_tdest)) != 4'b0000) ng_bad++;
        if (prev_stall) begin
          chk("stall_hold_valid", m_axis_tvalid, 1);
          chk("stall_hold_beat", {m_axis_tdest, m_axis_tdata}, prev_beat);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdest, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data 0x%0h dest %0d, expected no beat",
                     m_axis_tdata, m_axis_tdest);
          end else begin
            mon_e = exp_q.pop_front();
            chk("beat{data,dest,last}", {m_axis_tdata, m_axis_tdest, m_axis_tlast},
                {mon_e.d, mon_e.dest, mon_e.last});
          end
        end
        if (timeout_pulse) begin
          tp_count++;
          tp_cyc = cyc;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int          lc;
    int          n;
    logic [15:0] pat;
    aresetn       = 1'b0;
    m_axis_tready = 1'b0;
    pat           = 16'b1011_0010_1101_1001;

    // Reset state
    repeat (2) @(posedge aclk);
    #3;
    chk("reset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
                          busy, timeout_pulse, m_axis_tdata}, 0);
`ifdef ARB_STATS_EN
    chk("reset_stats", {grant_count, timeout_count}, 0);
`endif

    // Single requester, 3-byte packet
    do_reset();
    @(posedge aclk); #1;
    lc = cyc;
    src_push(2, 8'hA1, 0); src_push(2, 8'hA2, 0); src_push(2, 8'hA3, 1);
    exp_push(8'hA1, 2, 0); exp_push(8'hA2, 2, 0); exp_push(8'hA3, 2, 1);
    wait_drain(50, "t1_drain");
    chk("t1_first_latency", hs_at(0) - lc, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk); #1;
      if (busy) n++;
      else break;
    end
    chk("t1_gap_cycles", n, GAP);
    chk("t1_busy_low", busy, 0);

    // All four requesters, 1-beat packets: round-robin order and spacing
    do_reset();
    @(posedge aclk); #1;
    for (int i = 0; i < NR; i++) src_push(i, 8'h10 + 8'(i), 1);
    src_push(0, 8'h20, 1); src_push(1, 8'h21, 1);
    for (int i = 0; i < NR; i++) exp_push(8'h10 + 8'(i), 2'(i), 1);
    exp_push(8'h20, 0, 1); exp_push(8'h21, 1, 1);
    wait_drain(100, "t2_drain");
    for (int k = 1; k < 6; k++) chk("t2_beat_spacing", hs_at(k) - hs_at(k - 1), 6);

    // Long stream split by the burst limit, others served in between
    do_reset();
    @(posedge aclk); #1;
    for (int i = 0; i < 40; i++) src_push(1, 8'h40 + 8'(i), (i == 39));
    src_push(2, 8'hC0, 1);
    src_push(3, 8'hD0, 1);
    for (int i = 0; i < 16; i++) exp_push(8'h40 + 8'(i), 1, (i == 15));
    exp_push(8'hC0, 2, 1);
    exp_push(8'hD0, 3, 1);
    for (int i = 16; i < 32; i++) exp_push(8'h40 + 8'(i), 1, (i == 31));
    for (int i = 32; i < 40; i++) exp_push(8'h40 + 8'(i), 1, (i == 39));
    wait_drain(200, "t3_drain");
    chk("t3_no_timeout", tp_count, 0);

    // Idle timeout on requester 3
    do_reset();
    @(posedge aclk); #1;
    src_push(3, 8'hE1, 0); src_push(3, 8'hE2, 0);
    exp_push(8'hE1, 3, 0); exp_push(8'hE2, 3, 0); exp_push(8'hF0, 0, 1);
    repeat (5) @(posedge aclk);
    #1;
    src_push(0, 8'hF0, 1);
    wait_drain(150, "t4_drain");
    chk("t4_timeout_pulses", tp_count, 1);
    chk("t4_timeout_delay", tp_cyc - hs_at(1), 33);
    chk("t4_regrant_delay", hs_at(2) - hs_at(1), 38);
`ifdef ARB_STATS_EN
    chk("t4_timeout_count", timeout_count, 1);
    chk("t4_grant_count", grant_count, {16'd1, 16'd0, 16'd0, 16'd1});
`endif

    // Backpressure toggling mid-burst
    do_reset();
    @(posedge aclk); #1;
    for (int i = 0; i < 6; i++) src_push(1, 8'h31 + 8'(i), (i == 5));
    src_push(2, 8'h5A, 1);
    for (int i = 0; i < 6; i++) exp_push(8'h31 + 8'(i), 1, (i == 5));
    exp_push(8'h5A, 2, 1);
    for (int k = 0; k < 200; k++) begin
      @(posedge aclk); #1;
      m_axis_tready = pat[k % 16];
      if (exp_q.size() == 0) break;
    end
    m_axis_tready = 1'b1;
    chk("t5_drain", exp_q.size(), 0);
    chk("t5_nongrant_tready", ng_bad, 0);

    // Asynchronous reset during beat 5
    do_reset();
    @(posedge aclk); #1;
    for (int i = 0; i < 10; i++) src_push(1, 8'h81 + 8'(i), (i == 9));
    for (int i = 0; i < 4; i++) exp_push(8'h81 + 8'(i), 1, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk); #1;
      if (hs_cyc.size() >= 4) break;
    end
    @(posedge aclk); #3;
    chk("t6_beat5_valid", m_axis_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("t6_async_reset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
                                   busy, timeout_pulse}, 0);
    chk("t6_four_beats", exp_q.size(), 0);
`ifdef ARB_STATS_EN
    chk("t6_reset_stats", {grant_count, timeout_count}, 0);
`endif
    do_reset();
    @(posedge aclk); #1;
    src_push(2, 8'h88, 1);
    src_push(0, 8'h77, 1);
    exp_push(8'h77, 0, 1);
    exp_push(8'h88, 2, 1);
    wait_drain(50, "t6_drain");

    repeat (5) @(posedge aclk);
    chk("final_no_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
